// File: rtl/gl_cmd_sequencer_pkg.sv
// Shared opcode map, FSM state encodings and reset constants for the GL command sequencer.
package gl_defines;

  localparam logic [7:0] OP_PUSH     = 8'h01;
  localparam logic [7:0] OP_POP      = 8'h02;
  localparam logic [7:0] OP_VERTEX   = 8'h03;
  localparam logic [7:0] OP_COLOR    = 8'h04;
  localparam logic [7:0] OP_MODE     = 8'h10;
  localparam logic [7:0] OP_MUL_A    = 8'h11;
  localparam logic [7:0] OP_LOAD_ID  = 8'h12;
  localparam logic [7:0] OP_LOAD     = 8'h13;
  localparam logic [7:0] OP_MUL_B    = 8'h16;
  localparam logic [7:0] OP_MUL_C    = 8'h17;
  localparam logic [7:0] OP_MUL_D    = 8'h18;
  localparam logic [7:0] OP_VIEWPORT = 8'h19;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_MUL      = 3'd1;
  localparam logic [2:0] ST_LOAD     = 3'd2;
  localparam logic [2:0] ST_VTX_MV   = 3'd3;
  localparam logic [2:0] ST_VTX_PROJ = 3'd4;
  localparam logic [2:0] ST_VTX_DIV  = 3'd5;

  // 640.0 and 480.0 as IEEE-754 single precision
  localparam logic [31:0] VP_MAX_X_RST = 32'h44200000;
  localparam logic [31:0] VP_MAX_Y_RST = 32'h43F00000;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gl_stack_depth.sv
// Depth counter for one matrix stack; saturates at 0 and DEPTH, the owner decides on errors.
module gl_stack_depth #(
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o
);

  localparam int W = $clog2(DEPTH + 1);

  logic [W-1:0] depth_q, depth_d;

  assign full_o  = (depth_q == W'(DEPTH));
  assign empty_o = (depth_q == '0);

  always_comb begin
    depth_d = depth_q;
    if (push_i && !full_o) begin
      depth_d = depth_q + W'(1);
    end else if (pop_i && !empty_o) begin
      depth_d = depth_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/gl_cmd_sequencer.sv
// Decodes GL-style commands into single-cycle control pulses and timed multi-cycle sequences
// (matrix multiply, vertex transform, BRAM matrix load); one command in flight at a time.
module gl_cmd_sequencer
  import gl_defines::*;
#(
  parameter int MUL44_LAT   = 15,
  parameter int MUL41_LAT   = 6,
  parameter int DIV_LAT     = 2,
  parameter int LOAD_ROWS   = 4,
  parameter int ADDR_STRIDE = 16,
  parameter int STACK_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  opcode,
  input  logic [22:0] imm,
  input  logic [31:0] bram_addr_in,
  output logic [31:0] bram_addr_out,
  input  logic [31:0] bram_read_in_0,
  input  logic [31:0] bram_read_in_1,
  input  logic [31:0] bram_read_in_2,
  input  logic [31:0] bram_read_in_3,
  input  logic [31:0] color_in,
  output logic [31:0] color_out,
  output logic [31:0] viewport_min_x,
  output logic [31:0] viewport_min_y,
  output logic [31:0] viewport_max_x,
  output logic [31:0] viewport_max_y,
  output logic        push_en,
  output logic        pop_en,
  output logic        matrix_load_en,
  output logic        matrix_load_id_en,
  output logic        matrix_mul_en,
  output logic        perspective_div_en,
  output logic        matrix_mul_type,
  output logic        matrix_mode_out,
  output logic        stack_err,
  output logic        busy
);

  localparam int MAX_LAT = max_of(max_of(MUL44_LAT, MUL41_LAT), max_of(DIV_LAT, LOAD_ROWS));
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             curr_mode_q, curr_mode_d;
  logic             mul_type_q, mul_type_d;
  logic             mode_out_q, mode_out_d;
  logic             err_q, err_d;
  logic [31:0]      color_q, color_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      vp_min_x_q, vp_min_x_d, vp_min_y_q, vp_min_y_d;
  logic [31:0]      vp_max_x_q, vp_max_x_d, vp_max_y_q, vp_max_y_d;
  logic             push_en_q, push_en_d, pop_en_q, pop_en_d;
  logic             load_en_q, load_en_d, load_id_en_q, load_id_en_d;
  logic             mul_en_q, mul_en_d, div_en_q, div_en_d;

  logic       accept;
  logic       push_fire, pop_fire;
  logic [1:0] full, empty;
  logic       unused_imm;

  assign accept     = cmd_valid && cmd_ready;
  assign push_fire  = accept && (opcode == OP_PUSH) && !full[curr_mode_q];
  assign pop_fire   = accept && (opcode == OP_POP) && !empty[curr_mode_q];
  assign unused_imm = ^imm[22:1];

  // Index 0 tracks the projection stack, index 1 the modelview stack
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stack
      gl_stack_depth #(
        .DEPTH(STACK_DEPTH)
      ) u_depth (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_fire && (curr_mode_q == 1'(gi))),
        .pop_i  (pop_fire && (curr_mode_q == 1'(gi))),
        .full_o (full[gi]),
        .empty_o(empty[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    curr_mode_d  = curr_mode_q;
    mul_type_d   = mul_type_q;
    mode_out_d   = mode_out_q;
    err_d        = err_q;
    color_d      = color_q;
    addr_d       = addr_q;
    vp_min_x_d   = vp_min_x_q;
    vp_min_y_d   = vp_min_y_q;
    vp_max_x_d   = vp_max_x_q;
    vp_max_y_d   = vp_max_y_q;
    push_en_d    = 1'b0;
    pop_en_d     = 1'b0;
    load_en_d    = 1'b0;
    load_id_en_d = 1'b0;
    mul_en_d     = 1'b0;
    div_en_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (opcode)
            OP_PUSH: begin
              mode_out_d = curr_mode_q;
              push_en_d  = push_fire;
              if (!push_fire) err_d = 1'b1;
            end
            OP_POP: begin
              mode_out_d = curr_mode_q;
              pop_en_d   = pop_fire;
              if (!pop_fire) err_d = 1'b1;
            end
            OP_COLOR: color_d = color_in;
            OP_MODE:  curr_mode_d = imm[0];
            OP_LOAD_ID: begin
              load_id_en_d = 1'b1;
              mode_out_d   = curr_mode_q;
            end
            OP_VIEWPORT: begin
              vp_min_x_d = bram_read_in_0;
              vp_min_y_d = bram_read_in_1;
              vp_max_x_d = bram_read_in_2;
              vp_max_y_d = bram_read_in_3;
            end
            OP_MUL_A, OP_MUL_B, OP_MUL_C, OP_MUL_D: begin
              state_d    = ST_MUL;
              cnt_d      = CNT_W'(MUL44_LAT - 1);
              mul_en_d   = 1'b1;
              mul_type_d = 1'b1;
              mode_out_d = curr_mode_q;
            end
            OP_VERTEX: begin
              state_d    = ST_VTX_MV;
              cnt_d      = CNT_W'(MUL41_LAT - 1);
              mul_en_d   = 1'b1;
              mul_type_d = 1'b0;
              mode_out_d = 1'b1;
            end
            OP_LOAD: begin
              state_d    = ST_LOAD;
              cnt_d      = CNT_W'(LOAD_ROWS - 1);
              load_en_d  = 1'b1;
              addr_d     = bram_addr_in;
              mode_out_d = curr_mode_q;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_LOAD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d     = cnt_q - CNT_W'(1);
          load_en_d = 1'b1;
          addr_d    = addr_q + 32'(ADDR_STRIDE);
        end
      end
      ST_VTX_MV: begin
        if (cnt_q == '0) begin
          state_d    = ST_VTX_PROJ;
          cnt_d      = CNT_W'(MUL41_LAT - 1);
          mul_en_d   = 1'b1;
          mode_out_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_VTX_PROJ: begin
        if (cnt_q == '0) begin
          state_d  = ST_VTX_DIV;
          cnt_d    = CNT_W'(DIV_LAT - 1);
          div_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_VTX_DIV: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      curr_mode_q  <= 1'b0;
      mul_type_q   <= 1'b0;
      mode_out_q   <= 1'b0;
      err_q        <= 1'b0;
      color_q      <= '0;
      addr_q       <= '0;
      vp_min_x_q   <= '0;
      vp_min_y_q   <= '0;
      vp_max_x_q   <= VP_MAX_X_RST;
      vp_max_y_q   <= VP_MAX_Y_RST;
      push_en_q    <= 1'b0;
      pop_en_q     <= 1'b0;
      load_en_q    <= 1'b0;
      load_id_en_q <= 1'b0;
      mul_en_q     <= 1'b0;
      div_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      curr_mode_q  <= curr_mode_d;
      mul_type_q   <= mul_type_d;
      mode_out_q   <= mode_out_d;
      err_q        <= err_d;
      color_q      <= color_d;
      addr_q       <= addr_d;
      vp_min_x_q   <= vp_min_x_d;
      vp_min_y_q   <= vp_min_y_d;
      vp_max_x_q   <= vp_max_x_d;
      vp_max_y_q   <= vp_max_y_d;
      push_en_q    <= push_en_d;
      pop_en_q     <= pop_en_d;
      load_en_q    <= load_en_d;
      load_id_en_q <= load_id_en_d;
      mul_en_q     <= mul_en_d;
      div_en_q     <= div_en_d;
    end
  end

  assign cmd_ready          = (state_q == ST_IDLE);
  assign busy               = ~cmd_ready;
  assign bram_addr_out      = addr_q;
  assign color_out          = color_q;
  assign viewport_min_x     = vp_min_x_q;
  assign viewport_min_y     = vp_min_y_q;
  assign viewport_max_x     = vp_max_x_q;
  assign viewport_max_y     = vp_max_y_q;
  assign push_en            = push_en_q;
  assign pop_en             = pop_en_q;
  assign matrix_load_en     = load_en_q;
  assign matrix_load_id_en  = load_id_en_q;
  assign matrix_mul_en      = mul_en_q;
  assign perspective_div_en = div_en_q;
  assign matrix_mul_type    = mul_type_q;
  assign matrix_mode_out    = mode_out_q;
  assign stack_err          = err_q;

endmodule

// File: tb/tb_gl_cmd_sequencer.sv
// Bench for gl_cmd_sequencer: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized command traffic.
module tb_gl_cmd_sequencer;

  localparam int MUL44  = 15;
  localparam int M41    = 6;
  localparam int DIVL   = 2;
  localparam int ROWS   = 4;
  localparam int STRIDE = 16;
  localparam int SDEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  opcode = '0;
  logic [22:0] imm = '0;
  logic [31:0] bram_addr_in = '0;
  logic [31:0] bram_addr_out;
  logic [31:0] bram_read_in_0 = '0, bram_read_in_1 = '0, bram_read_in_2 = '0, bram_read_in_3 = '0;
  logic [31:0] color_in = '0;
  logic [31:0] color_out;
  logic [31:0] viewport_min_x, viewport_min_y, viewport_max_x, viewport_max_y;
  logic        push_en, pop_en, matrix_load_en, matrix_load_id_en, matrix_mul_en, perspective_div_en;
  logic        matrix_mul_type, matrix_mode_out, stack_err, busy;

  always #5 clk = ~clk;

  gl_cmd_sequencer #(
    .MUL44_LAT(MUL44), .MUL41_LAT(M41), .DIV_LAT(DIVL),
    .LOAD_ROWS(ROWS), .ADDR_STRIDE(STRIDE), .STACK_DEPTH(SDEPTH)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .opcode(opcode), .imm(imm), .bram_addr_in(bram_addr_in), .bram_addr_out(bram_addr_out),
    .bram_read_in_0(bram_read_in_0), .bram_read_in_1(bram_read_in_1),
    .bram_read_in_2(bram_read_in_2), .bram_read_in_3(bram_read_in_3),
    .color_in(color_in), .color_out(color_out),
    .viewport_min_x(viewport_min_x), .viewport_min_y(viewport_min_y),
    .viewport_max_x(viewport_max_x), .viewport_max_y(viewport_max_y),
    .push_en(push_en), .pop_en(pop_en), .matrix_load_en(matrix_load_en),
    .matrix_load_id_en(matrix_load_id_en), .matrix_mul_en(matrix_mul_en),
    .perspective_div_en(perspective_div_en), .matrix_mul_type(matrix_mul_type),
    .matrix_mode_out(matrix_mode_out), .stack_err(stack_err), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: expected outputs for the current cycle
  logic        m_ready = 1'b0;
  logic [31:0] m_color, m_vp_min_x, m_vp_min_y, m_vp_max_x, m_vp_max_y, m_addr, m_base;
  logic        m_mode_out, m_type, m_err, m_curr_mode;
  logic        m_push, m_pop, m_load, m_lid, m_mul, m_div;
  int          m_depth [2];
  int          m_kind, m_t, m_busy_end;  // kind: 0 none, 1 mat44 mul, 2 vertex, 3 load

  // Observations gathered for the directed literal checks
  int o_mul, o_div, o_push, o_pop, o_load;
  int o_mul_cyc[$];
  int o_div_cyc[$];
  logic o_mul_mode[$];
  logic o_mul_type[$];
  logic [31:0] o_addr[$];

  logic [7:0]  ops [21] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12,
                           8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h00, 8'hFF, 8'h10};
  logic [31:0] exp_addr [4] = '{32'h100, 32'h110, 32'h120, 32'h130};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_advance();
    int cm;
    cyc++;
    {m_push, m_pop, m_load, m_lid, m_mul, m_div} = '0;
    if (rst) begin
      m_color = '0; m_addr = '0; m_vp_min_x = '0; m_vp_min_y = '0;
      m_vp_max_x = 32'h44200000; m_vp_max_y = 32'h43F00000;
      m_mode_out = 0; m_type = 0; m_err = 0; m_curr_mode = 0;
      m_depth[0] = 0; m_depth[1] = 0;
      m_kind = 0; m_busy_end = cyc; m_ready = 1'b1;
      return;
    end
    cm = int'(m_curr_mode);
    if (cmd_valid && m_ready) begin
      case (opcode)
        8'h01: begin
          m_mode_out = m_curr_mode;
          if (m_depth[cm] < SDEPTH) begin m_depth[cm]++; m_push = 1; end
          else m_err = 1;
        end
        8'h02: begin
          m_mode_out = m_curr_mode;
          if (m_depth[cm] > 0) begin m_depth[cm]--; m_pop = 1; end
          else m_err = 1;
        end
        8'h04: m_color = color_in;
        8'h10: m_curr_mode = imm[0];
        8'h12: begin m_lid = 1; m_mode_out = m_curr_mode; end
        8'h19: begin
          m_vp_min_x = bram_read_in_0; m_vp_min_y = bram_read_in_1;
          m_vp_max_x = bram_read_in_2; m_vp_max_y = bram_read_in_3;
        end
        8'h11, 8'h16, 8'h17, 8'h18: begin
          m_kind = 1; m_t = cyc; m_busy_end = cyc + MUL44;
          m_mode_out = m_curr_mode; m_type = 1;
        end
        8'h03: begin m_kind = 2; m_t = cyc; m_busy_end = cyc + 2 * M41 + DIVL; end
        8'h13: begin
          m_kind = 3; m_t = cyc; m_base = bram_addr_in; m_busy_end = cyc + ROWS;
          m_mode_out = m_curr_mode;
        end
        default: ;
      endcase
    end
    if (m_kind == 1 && cyc == m_t) m_mul = 1;
    if (m_kind == 2) begin
      if (cyc == m_t) begin m_mul = 1; m_type = 0; m_mode_out = 1; end
      if (cyc == m_t + M41) begin m_mul = 1; m_mode_out = 0; end
      if (cyc == m_t + 2 * M41) m_div = 1;
    end
    if (m_kind == 3 && cyc >= m_t && cyc < m_t + ROWS) begin
      m_load = 1;
      m_addr = m_base + 32'((cyc - m_t) * STRIDE);
    end
    m_ready = (cyc >= m_busy_end);
  endtask

  task automatic compare();
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
    chk("busy", 32'(busy), 32'(!m_ready));
    chk("color_out", color_out, m_color);
    chk("vp_min_x", viewport_min_x, m_vp_min_x);
    chk("vp_min_y", viewport_min_y, m_vp_min_y);
    chk("vp_max_x", viewport_max_x, m_vp_max_x);
    chk("vp_max_y", viewport_max_y, m_vp_max_y);
    chk("bram_addr_out", bram_addr_out, m_addr);
    chk("matrix_mode_out", 32'(matrix_mode_out), 32'(m_mode_out));
    chk("matrix_mul_type", 32'(matrix_mul_type), 32'(m_type));
    chk("stack_err", 32'(stack_err), 32'(m_err));
    chk("push_en", 32'(push_en), 32'(m_push));
    chk("pop_en", 32'(pop_en), 32'(m_pop));
    chk("matrix_load_en", 32'(matrix_load_en), 32'(m_load));
    chk("matrix_load_id_en", 32'(matrix_load_id_en), 32'(m_lid));
    chk("matrix_mul_en", 32'(matrix_mul_en), 32'(m_mul));
    chk("perspective_div_en", 32'(perspective_div_en), 32'(m_div));
  endtask

  task automatic observe();
    if (matrix_mul_en) begin
      o_mul++; o_mul_cyc.push_back(cyc);
      o_mul_mode.push_back(matrix_mode_out); o_mul_type.push_back(matrix_mul_type);
    end
    if (perspective_div_en) begin o_div++; o_div_cyc.push_back(cyc); end
    if (push_en) o_push++;
    if (pop_en) o_pop++;
    if (matrix_load_en) begin o_load++; o_addr.push_back(bram_addr_out); end
  endtask

  task automatic clear_obs();
    o_mul = 0; o_div = 0; o_push = 0; o_pop = 0; o_load = 0;
    o_mul_cyc.delete(); o_div_cyc.delete(); o_mul_mode.delete(); o_mul_type.delete(); o_addr.delete();
  endtask

  task automatic tick(input logic v, input logic [7:0] op, input logic [22:0] im, input logic r);
    cmd_valid = v; opcode = op; imm = im; rst = r;
    color_in = $urandom;
    bram_read_in_0 = $urandom; bram_read_in_1 = $urandom;
    bram_read_in_2 = $urandom; bram_read_in_3 = $urandom;
    if (v && m_ready && !r)
      $display("txn cyc=%0d op=%02h imm=%06h addr_in=%08h", cyc + 1, op, im, bram_addr_in);
    @(posedge clk);
    #1;
    model_advance();
    compare();
    observe();
  endtask

  task automatic wait_ready(input int maxc, output int rc);
    int n = 0;
    while (!cmd_ready && n < maxc) begin
      tick(1'b0, 8'h00, 23'd0, 1'b0);
      n++;
    end
    chk("wait_ready_bound", 32'(cmd_ready), 32'd1);
    rc = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, rc;
    tick(1'b0, 8'h00, 23'd0, 1'b1);
    tick(1'b0, 8'h00, 23'd0, 1'b1);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_vp_max_x", viewport_max_x, 32'h44200000);
    chk("rst_vp_max_y", viewport_max_y, 32'h43F00000);
    chk("rst_color", color_out, 32'd0);

    // Full 4x4 multiply
    clear_obs();
    tick(1'b1, 8'h18, 23'd0, 1'b0);
    t0 = cyc;
    wait_ready(40, rc);
    chk("mul44_busy_cycles", 32'(rc - t0), 32'd15);
    chk("mul44_pulses", 32'(o_mul), 32'd1);
    if (o_mul_type.size() == 1) chk("mul44_type", 32'(o_mul_type[0]), 32'd1);

    // Vertex transform in projection mode
    tick(1'b1, 8'h10, 23'd0, 1'b0);
    clear_obs();
    tick(1'b1, 8'h03, 23'd0, 1'b0);
    t0 = cyc;
    wait_ready(40, rc);
    chk("vtx_mul_pulses", 32'(o_mul), 32'd2);
    if (o_mul_cyc.size() == 2) begin
      chk("vtx_mul0_t", 32'(o_mul_cyc[0] - t0), 32'd0);
      chk("vtx_mul1_t", 32'(o_mul_cyc[1] - t0), 32'd6);
      chk("vtx_mul0_mode", 32'(o_mul_mode[0]), 32'd1);
      chk("vtx_mul1_mode", 32'(o_mul_mode[1]), 32'd0);
      chk("vtx_mul_type", 32'(o_mul_type[1]), 32'd0);
    end
    chk("vtx_div_pulses", 32'(o_div), 32'd1);
    if (o_div_cyc.size() == 1) chk("vtx_div_t", 32'(o_div_cyc[0] - t0), 32'd12);
    chk("vtx_ready_t", 32'(rc - t0), 32'd14);

    // Matrix load from BRAM, then one that wraps the address space
    bram_addr_in = 32'h100;
    clear_obs();
    tick(1'b1, 8'h13, 23'd0, 1'b0);
    wait_ready(20, rc);
    chk("load_rows", 32'(o_load), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < o_addr.size()) chk("load_addr", o_addr[k], exp_addr[k]);
    bram_addr_in = 32'hFFFF_FFF0;
    clear_obs();
    tick(1'b1, 8'h13, 23'd0, 1'b0);
    wait_ready(20, rc);
    if (o_addr.size() == 4) chk("load_wrap_addr", o_addr[2], 32'h0000_0010);

    // Stack overflow in modelview, underflow in projection
    tick(1'b0, 8'h00, 23'd0, 1'b1);
    tick(1'b1, 8'h10, 23'd1, 1'b0);
    clear_obs();
    repeat (33) tick(1'b1, 8'h01, 23'd0, 1'b0);
    chk("push_pulses", 32'(o_push), 32'd32);
    chk("stack_err_overflow", 32'(stack_err), 32'd1);
    tick(1'b1, 8'h10, 23'd0, 1'b0);
    clear_obs();
    tick(1'b1, 8'h02, 23'd0, 1'b0);
    tick(1'b0, 8'h00, 23'd0, 1'b0);
    chk("pop_at_empty", 32'(o_pop), 32'd0);

    // Reset in the middle of a vertex sequence
    tick(1'b0, 8'h00, 23'd0, 1'b1);
    tick(1'b1, 8'h03, 23'd0, 1'b0);
    repeat (3) tick(1'b0, 8'h00, 23'd0, 1'b0);
    tick(1'b0, 8'h00, 23'd0, 1'b1);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_vp_max_x", viewport_max_x, 32'h44200000);
    chk("rst_mid_mul_en", 32'(matrix_mul_en), 32'd0);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      logic       v, r;
      logic [7:0] op;
      bram_addr_in = $urandom;
      v  = ($urandom_range(0, 9) < 6);
      op = ops[$urandom_range(0, 20)];
      r  = ($urandom_range(0, 299) == 0);
      tick(v, op, 23'($urandom), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gl_cmd_sequencer.md
GL_CMD_SEQUENCER -- requirements
Module: gl_cmd_sequencer

Interface
REQ-001 Parameter: MUL44_LAT, 15, cycles from matrix_mul_en pulse to 4x4*4x4 result valid (>=1).
REQ-002 Parameter: MUL41_LAT, 6, cycles for a 4x4*4x1 multiply (>=1).
REQ-003 Parameter: DIV_LAT, 2, perspective-division cycles (>=1).
REQ-004 Parameter: LOAD_ROWS, 4, BRAM row reads per LOADMATRIX (>=1).
REQ-005 Parameter: ADDR_STRIDE, 16, byte increment between BRAM rows.
REQ-006 Parameter: STACK_DEPTH, 32, matrix-stack entries per mode (>=1).
REQ-007 Ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-008 Ports: cmd_valid in 1; cmd_ready out 1; opcode in 8; imm in 23.
REQ-009 Ports: bram_addr_in in 32 base address; bram_addr_out out 32; bram_read_in_0..3 in 32 each.
REQ-010 Ports: color_in in 32; color_out out 32; viewport_min_x/min_y/max_x/max_y out 32 each.
REQ-011 Ports: push_en, pop_en, matrix_load_en, matrix_load_id_en, matrix_mul_en, perspective_div_en out 1 (single-cycle pulses).
REQ-012 Ports: matrix_mul_type out 1 (1=4x4*4x4, 0=4x4*4x1); matrix_mode_out out 1 (1=modelview, 0=projection); stack_err out 1 sticky; busy out 1 (=~cmd_ready).

Function
REQ-013 A command SHALL be accepted only on a cycle with cmd_valid && cmd_ready; opcode/imm captured at acceptance.
REQ-014 FSM states SHALL be IDLE, MUL, LOAD, VTX_MV, VTX_PROJ, VTX_DIV; cmd_ready=1 only in IDLE.
REQ-015 Single-cycle opcodes (0x01,0x02,0x04,0x10,0x12,0x14,0x15,0x19,0x1A, unknown) SHALL update outputs on the next edge and stay in IDLE.
REQ-016 0x04: color_out<=color_in; 0x10: curr_mode<=imm[0]; 0x19: viewport regs<=bram_read_in_0..3; 0x12: matrix_load_id_en pulse, matrix_mode_out<=curr_mode.
REQ-017 0x11/0x16/0x17/0x18: one-cycle matrix_mul_en, matrix_mul_type=1, matrix_mode_out=curr_mode; enter MUL; return to IDLE after exactly MUL44_LAT cycles.
REQ-018 0x03: VTX_MV pulse mul_en, type=0, mode=1, MUL41_LAT cycles; VTX_PROJ pulse mul_en, mode=0, MUL41_LAT cycles; VTX_DIV pulse perspective_div_en, DIV_LAT cycles; then IDLE (total 2*MUL41_LAT+DIV_LAT).
REQ-019 0x13: LOAD for LOAD_ROWS cycles; matrix_load_en high throughout; bram_addr_out = bram_addr_in + k*ADDR_STRIDE on row k (k=0..LOAD_ROWS-1), modulo 2^32.
REQ-020 A per-mode depth counter (0..STACK_DEPTH) SHALL increment on push, decrement on pop.
REQ-021 Push at depth STACK_DEPTH or pop at depth 0 SHALL suppress the pulse, leave depth unchanged, set stack_err.
REQ-022 stack_err SHALL clear only on rst.
REQ-023 Pulse outputs SHALL be low in every cycle other than specified.
REQ-024 cmd_valid while busy SHALL be ignored; the command is not lost since the producer holds it.
REQ-025 Latency counter width SHALL be $clog2(max latency)+1.

Reset
REQ-026 rst SHALL force IDLE from any state, abort in-flight sequences, clear all pulses, curr_mode, matrix_mul_type, matrix_mode_out, depths, stack_err, color_out, bram_addr_out and viewport_min_x/y to 0.
REQ-027 On rst, viewport_max_x SHALL become 32'h44200000 (640.0) and viewport_max_y 32'h43F00000 (480.0).
REQ-028 Outputs SHALL hold these values on the first edge after rst.

Structure
REQ-029 Opcode constants and FSM state encodings SHALL live in a shared gl_defines package/include.
REQ-030 Depth tracking SHALL be one sub-module gl_stack_depth, instantiated twice (per mode).

Verification
REQ-031 0x18 with defaults -> one mul_en pulse, type=1; cmd_ready low 15 cycles, then high.
REQ-032 0x10 imm=0 then 0x03 -> mul_en pulses at t and t+6 (mode 1 then 0), div pulse at t+12, ready at t+14.
REQ-033 0x13 with bram_addr_in=0x100 -> addresses 0x100,0x110,0x120,0x130; load_en high 4 cycles.
REQ-034 33 pushes in mode 1 -> 32 push_en pulses, stack_err=1 on 33rd; pop in mode 0 at depth 0 -> no pop_en.
REQ-035 rst asserted mid-0x03 at cycle 4 -> next edge IDLE, cmd_ready=1, viewport_max_x=32'h44200000.
